// File: rtl/perf_event_monitor.sv
// perf_event_monitor: one free-running cycle counter plus N_EVT event counters.
// A four-state run controller gates counting. Overflow flags are sticky, and
// the read port returns a registered value one cycle after the request.
module perf_event_monitor #(
   parameter int CNT_W      = 32,
   parameter int N_EVT      = 4,
   parameter int SATURATE   = 0,
   parameter int MAX_CYCLES = 0
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       start_i,
   input  logic                       clear_i,
   input  logic                       freeze_i,
   input  logic [N_EVT-1:0]           evt_i,
   input  logic                       rd_en_i,
   input  logic [$clog2(N_EVT+1)-1:0] rd_sel_i,
   output logic [CNT_W-1:0]           rd_data_o,
   output logic                       rd_valid_o,
   output logic [N_EVT:0]             ovf_o,
   output logic                       running_o,
   output logic                       done_o
);

   localparam int SEL_W = $clog2(N_EVT + 1);
   localparam int N_CNT = N_EVT + 1;
   localparam logic [CNT_W-1:0] ALL_ONES  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   // Value the cycle counter holds on the edge that must take it to MAX_CYCLES.
   localparam logic [CNT_W-1:0] LIMIT_M1  = CNT_W'(MAX_CYCLES - 32'sd1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FROZEN = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t            state_r;
   state_t            state_next_s;
   logic              running_next_s;
   logic              done_next_s;
   logic              running_r;
   logic              done_r;
   logic              count_en_s;
   logic              limit_hit_s;
   logic [N_EVT:0]    inc_s;
   logic [N_EVT:0]    ovf_r;
   logic [CNT_W-1:0]  cnt_r [N_CNT];
   logic [CNT_W-1:0]  rd_mux_s;
   logic [CNT_W-1:0]  rd_data_r;
   logic              rd_valid_r;

   // Count qualifiers: a RUN cycle counts unless it is being frozen or cleared;
   // index 0 is the cycle counter, index k is event channel k-1.
   always_comb begin
      count_en_s  = (state_r == ST_RUN) && !freeze_i && !clear_i;
      limit_hit_s = (MAX_CYCLES != 0) && count_en_s && (cnt_r[0] == LIMIT_M1);
      inc_s       = {evt_i, 1'b1} & {N_CNT{count_en_s}};
   end

   // Next-state logic: clear wins, then the cycle limit, then freeze, then start.
   always_comb begin
      state_next_s = state_r;
      if (clear_i) begin
         state_next_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE:   state_next_s = start_i ? ST_RUN : ST_IDLE;
            ST_RUN: begin
               if (limit_hit_s) begin
                  state_next_s = ST_DONE;
               end else if (freeze_i) begin
                  state_next_s = ST_FROZEN;
               end else begin
                  state_next_s = ST_RUN;
               end
            end
            ST_FROZEN: state_next_s = freeze_i ? ST_FROZEN : ST_RUN;
            ST_DONE:   state_next_s = ST_DONE;
            default:   state_next_s = ST_IDLE;
         endcase
      end
   end

   // Output decode from the next state so the status flags can be registered.
   always_comb begin
      running_next_s = (state_next_s == ST_RUN);
      done_next_s    = (state_next_s == ST_DONE);
   end

   // State register and registered status outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r   <= ST_IDLE;
         running_r <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_next_s;
         running_r <= running_next_s;
         done_r    <= done_next_s;
      end
   end

   // Counters and sticky overflow flags; all-ones either wraps or saturates.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         for (int k = 0; k < N_CNT; k++) begin
            cnt_r[k] <= '0;
         end
         ovf_r <= '0;
      end else begin
         for (int k = 0; k < N_CNT; k++) begin
            if (inc_s[k]) begin
               if (cnt_r[k] == ALL_ONES) begin
                  ovf_r[k] <= 1'b1;
                  cnt_r[k] <= (SATURATE != 0) ? ALL_ONES : '0;
               end else begin
                  cnt_r[k] <= cnt_r[k] + CNT_ONE;
               end
            end
         end
      end
   end

   // Read mux over the current (pre-update) counter values; unmapped indices read 0.
   always_comb begin
      rd_mux_s = '0;
      for (int k = 0; k < N_CNT; k++) begin
         rd_mux_s = rd_mux_s | ((rd_sel_i == SEL_W'(k)) ? cnt_r[k] : '0);
      end
   end

   // Registered read port: one-cycle latency, a valid pulse per request.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_data_r  <= '0;
         rd_valid_r <= 1'b0;
      end else begin
         rd_valid_r <= rd_en_i;
         if (rd_en_i) begin
            rd_data_r <= rd_mux_s;
         end
      end
   end

   assign rd_data_o  = rd_data_r;
   assign rd_valid_o = rd_valid_r;
   assign ovf_o      = ovf_r;
   assign running_o  = running_r;
   assign done_o     = done_r;

endmodule
